prog_counter: RTL and testbench



---
 rtl/prog_counter.sv | 151 +++++++++++++++
 tb/tb_prog_counter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
//  Module   : prog_counter
//  Purpose  : Fetch-stage program counter. Drives the registered ROM address
//             prog_ctr and sequences IDLE -> RUN -> HALT. In RUN it applies,
//             in falling priority: halt, stall, absolute branch, PC-relative
//             branch, and sequential increment. All arithmetic wraps modulo
//             2**D.
//  Options  : PC_CYCLE_CNT_EN - when defined, adds a 16-bit saturating
//             cycle_count output that counts cycles spent in RUN.
//  Revision : 1.0  initial release
// ============================================================================
module prog_counter #(
    parameter int                D          = 12,
    parameter int                OFF_W      = 8,
    parameter logic [D-1:0]      START_ADDR = '0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Halt,
    input  logic                 Stall,
    input  logic                 BranchAbs,
    input  logic                 BranchRel,
    input  logic                 Taken,
    input  logic [D-1:0]         Target,
    input  logic [OFF_W-1:0]     Offset,
    output logic [D-1:0]         prog_ctr,
    output logic                 Running,
    output logic                 Done
`ifdef PC_CYCLE_CNT_EN
    ,
    output logic [15:0]          cycle_count
`endif
);

    // ------------------------------------------------------------------------
    // State encoding. The spare code 2'b11 is steered back to IDLE.
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_halt = 2'd2;

    // ------------------------------------------------------------------------
    // Elaboration-time legality check: a relative offset wider than the PC
    // cannot be sign-extended into it.
    // ------------------------------------------------------------------------
    generate
        if (OFF_W > D) begin : g_bad_off_w
            $error("prog_counter: OFF_W (%0d) must not exceed D (%0d)", OFF_W, D);
        end
    endgenerate

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    logic [D-1:0] r_pc;
    logic [D-1:0] w_pc_next;
    logic [D-1:0] w_off_sext;
    logic         w_start_run;

    // ------------------------------------------------------------------------
    // Sign-extend the relative offset to the PC width. A zero-width
    // replication is avoided when the widths already match.
    // ------------------------------------------------------------------------
    generate
        if (D > OFF_W) begin : g_sext_pad
            assign w_off_sext = {{(D-OFF_W){Offset[OFF_W-1]}}, Offset};
        end else begin : g_sext_full
            assign w_off_sext = D'(Offset);
        end
    endgenerate

    // A Start that actually enters RUN (ignored while already running).
    assign w_start_run = Start && ((r_state == c_st_idle) || (r_state == c_st_halt));

    // Next-state and next-PC selection with the RUN-state priority chain.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        case (r_state)
            c_st_idle: begin
                if (Start) begin
                    w_state_next = c_st_run;
                    w_pc_next    = START_ADDR;
                end
            end
            c_st_run: begin
                if (Halt) begin
                    w_state_next = c_st_halt;
                end else if (Stall) begin
                    w_pc_next = r_pc;
                end else if (BranchAbs && Taken) begin
                    w_pc_next = Target;
                end else if (BranchRel && Taken) begin
                    // Carry out of the add is dropped: modulo 2**D.
                    w_pc_next = r_pc + w_off_sext;
                end else begin
                    w_pc_next = r_pc + D'(1);
                end
            end
            c_st_halt: begin
                if (Start) begin
                    w_state_next = c_st_run;
                    w_pc_next    = START_ADDR;
                end
            end
            default: begin
                w_state_next = c_st_idle;
                w_pc_next    = '0;
            end
        endcase
    end

    // State and PC registers; Reset overrides every other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_st_idle;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    assign prog_ctr = r_pc;
    assign Running  = (r_state == c_st_run);
    assign Done     = (r_state == c_st_halt);

`ifdef PC_CYCLE_CNT_EN
    logic [15:0] r_cycle_cnt;

    // Saturating count of cycles spent in RUN, stalled cycles included.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cycle_cnt <= '0;
        end else if (w_start_run) begin
            r_cycle_cnt <= '0;
        end else if ((r_state == c_st_run) && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign cycle_count = r_cycle_cnt;
`else
    // Start qualification is only consumed by the optional cycle counter.
    logic w_unused;
    assign w_unused = w_start_run;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_counter
//  Purpose  : Self-checking bench for prog_counter. A behavioural model
//             predicts each cycle's outputs, pushes them to a scoreboard
//             queue, and the entry is popped and compared after the edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_counter;

    localparam int D     = 12;
    localparam int OFF_W = 8;

    logic             Clk = 1'b0;
    logic             Reset, Start, Halt, Stall, BranchAbs, BranchRel, Taken;
    logic [D-1:0]     Target;
    logic [OFF_W-1:0] Offset;
    logic [D-1:0]     prog_ctr;
    logic             Running, Done;
`ifdef PC_CYCLE_CNT_EN
    logic [15:0]      cycle_count;
`endif

    prog_counter #(.D(D), .OFF_W(OFF_W), .START_ADDR(12'd0)) u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Halt      (Halt),
        .Stall     (Stall),
        .BranchAbs (BranchAbs),
        .BranchRel (BranchRel),
        .Taken     (Taken),
        .Target    (Target),
        .Offset    (Offset),
        .prog_ctr  (prog_ctr),
        .Running   (Running),
        .Done      (Done)
`ifdef PC_CYCLE_CNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        logic [11:0] pc;
        logic        run;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: 0 idle, 1 run, 2 halt.
    int          m_state = 0;
    logic [11:0] m_pc    = '0;
    logic [15:0] m_cnt   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge.
    task automatic step(input string tag, input logic rst, input logic st, input logic hl,
                        input logic sl, input logic ba, input logic br, input logic tk,
                        input logic [11:0] tg, input logic [7:0] of);
        exp_t e;
        exp_t g;
        @(negedge Clk);
        Reset = rst; Start = st; Halt = hl; Stall = sl;
        BranchAbs = ba; BranchRel = br; Taken = tk; Target = tg; Offset = of;
        if (rst) begin
            m_state = 0; m_pc = '0; m_cnt = '0;
        end else if (m_state == 1) begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (hl)            m_state = 2;
            else if (sl)       m_pc = m_pc;
            else if (ba && tk) m_pc = tg;
            else if (br && tk) m_pc = m_pc + 12'($signed(of));
            else               m_pc = m_pc + 12'd1;
        end else if (st) begin
            m_state = 1; m_pc = 12'd0; m_cnt = '0;
        end
        e.tag = tag; e.pc = m_pc; e.run = (m_state == 1);
        e.done = (m_state == 2); e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        g = sb.pop_front();
        check({g.tag, ".pc"},   32'(prog_ctr), 32'(g.pc));
        check({g.tag, ".run"},  32'(Running),  32'(g.run));
        check({g.tag, ".done"}, 32'(Done),     32'(g.done));
`ifdef PC_CYCLE_CNT_EN
        check({g.tag, ".cnt"},  32'(cycle_count), 32'(g.cnt));
`endif
    endtask

    task automatic plain(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Halt = 1'b0; Stall = 1'b0;
        BranchAbs = 1'b0; BranchRel = 1'b0; Taken = 1'b0;
        Target = '0; Offset = '0;

        // Reset then idle; IDLE ignores branch/halt noise.
        step("rst0", 1, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        for (int i = 0; i < 5; i++)
            step("idle", 0, 0, i[0], i[1], 1, 1, 1, 12'h555, 8'h11);

        // Start and sequential fetch 0..4.
        step("start", 0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        for (int i = 0; i < 4; i++) plain("seq");
        // Start ignored in RUN.
        step("start_in_run", 0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        for (int i = 0; i < 5; i++) plain("to10");

        // Relative branches around 10.
        step("rel_neg", 0, 0, 0, 0, 0, 1, 1, 12'h000, 8'hFD);
        step("rel_pos", 0, 0, 0, 0, 0, 1, 1, 12'h000, 8'h05);
        step("rel_nt",  0, 0, 0, 0, 0, 1, 0, 12'h000, 8'h05);
        step("abs_nt",  0, 0, 0, 0, 1, 0, 0, 12'h444, 8'h00);

        // Wrap at the top of the address space and abs-over-rel priority.
        step("abs_fff", 0, 0, 0, 0, 1, 0, 1, 12'hFFF, 8'h00);
        plain("wrap");
        step("rel_wrap", 0, 0, 0, 0, 0, 1, 1, 12'h000, 8'hFF);
        step("both_br", 0, 0, 0, 0, 1, 1, 1, 12'h800, 8'h7F);

        // Stall, halt with stall, halt hold, restart.
        step("abs_20", 0, 0, 0, 0, 1, 0, 1, 12'd20, 8'h00);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 0, 0, 1, 1, 1, 1, 12'h123, 8'h04);
        step("halt_stall", 0, 0, 1, 1, 0, 0, 0, 12'h000, 8'h00);
        step("halt_hold", 0, 0, 0, 0, 1, 0, 1, 12'h321, 8'h00);
        plain("halt_hold2");
        step("restart", 0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        plain("after_restart");

        // Reset mid-run aborts to IDLE.
        step("abs_37", 0, 0, 0, 0, 1, 0, 1, 12'd37, 8'h00);
        step("rst_mid", 1, 1, 0, 0, 1, 0, 1, 12'h456, 8'h00);
        plain("idle_after_rst");

        // Five RUN cycles including two stalled ones.
        step("start2", 0, 1, 0, 0, 0, 0, 0, 12'h000, 8'h00);
        plain("c1");
        step("c2_stall", 0, 0, 0, 1, 0, 0, 0, 12'h000, 8'h00);
        plain("c3");
        step("c4_stall", 0, 0, 0, 1, 0, 0, 0, 12'h000, 8'h00);
        step("c5_halt", 0, 0, 1, 0, 0, 0, 0, 12'h000, 8'h00);
        plain("halt_cnt_hold");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
